// File: rtl/score_keeper_if.sv
// Game-side bundle between the playfield logic and the score keeper.
// master = playfield/stimulus side, slave = score keeper.
interface score_keeper_if #(
  parameter int SCORE_W = 7
);
  logic               l_point;
  logic               r_point;
  logic               new_game;
  logic               reset_round;
  logic               game_over;
  logic               winner;
  logic [SCORE_W-1:0] l_score;
  logic [SCORE_W-1:0] r_score;
  logic [6:0]         l_hex1;
  logic [6:0]         l_hex0;
  logic [6:0]         r_hex1;
  logic [6:0]         r_hex0;

  modport master (
    output l_point, r_point, new_game,
    input  reset_round, game_over, winner, l_score, r_score,
           l_hex1, l_hex0, r_hex1, r_hex0
  );

  modport slave (
    input  l_point, r_point, new_game,
    output reset_round, game_over, winner, l_score, r_score,
           l_hex1, l_hex0, r_hex1, r_hex0
  );
endinterface

// File: rtl/score_keeper.sv
// Two-player score keeper: one point per round, win/deuce detection, registered 7-seg digits.
// Point edge in cycle N -> score in N+1, reset_round/game_over in N+2; no backpressure, off-IDLE edges dropped.
module score_keeper #(
  parameter int WIN_SCORE  = 7,
  parameter int WIN_BY_TWO = 0,
  parameter int SCORE_W    = 7
) (
  input logic           clk,
  input logic           reset,
  score_keeper_if.slave sk
);
  typedef enum logic [1:0] {IDLE, CHECK, ROUND, GAME_OVER} state_t;

  localparam logic [SCORE_W-1:0] WIN         = SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W-1:0] DEUCE_SCORE = SCORE_W'(WIN_SCORE - 1);
  localparam logic [SCORE_W-1:0] ONE         = SCORE_W'(1);
  localparam logic [SCORE_W-1:0] TEN         = SCORE_W'(10);
  localparam logic [SCORE_W:0]   LEAD        = (SCORE_W + 1)'(2);

  state_t             state, state_n;
  logic               l_point_d, r_point_d;
  logic               l_edge, r_edge;
  logic [SCORE_W-1:0] l_score, r_score, l_score_n, r_score_n;
  logic               game_over, game_over_n;
  logic               winner, winner_n;
  logic               l_wins, r_wins, deuce;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  // {tens, ones}; tens blanked below 10
  function automatic logic [13:0] hex_pair(input logic [SCORE_W-1:0] s);
    logic [6:0] tens;
    tens = (s < TEN) ? 7'b1111111 : seg7(4'(s / TEN));
    hex_pair = {tens, seg7(4'(s % TEN))};
  endfunction

  assign l_edge = sk.l_point & ~l_point_d;
  assign r_edge = sk.r_point & ~r_point_d;

  assign l_wins = (l_score >= WIN) &&
                  ((WIN_BY_TWO == 0) || ({1'b0, l_score} >= {1'b0, r_score} + LEAD));
  assign r_wins = (r_score >= WIN) &&
                  ((WIN_BY_TWO == 0) || ({1'b0, r_score} >= {1'b0, l_score} + LEAD));
  assign deuce  = (WIN_BY_TWO != 0) && (l_score == r_score) && (l_score >= WIN);

  always_comb begin
    state_n     = state;
    l_score_n   = l_score;
    r_score_n   = r_score;
    game_over_n = game_over;
    winner_n    = winner;
    if (sk.new_game) begin
      state_n     = ROUND;
      l_score_n   = '0;
      r_score_n   = '0;
      game_over_n = 1'b0;
      winner_n    = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (l_edge && r_edge) begin
            state_n = ROUND;
          end else if (l_edge) begin
            l_score_n = l_score + ONE;
            state_n   = CHECK;
          end else if (r_edge) begin
            r_score_n = r_score + ONE;
            state_n   = CHECK;
          end
        end
        CHECK: begin
          if (l_wins) begin
            state_n     = GAME_OVER;
            game_over_n = 1'b1;
            winner_n    = 1'b0;
          end else if (r_wins) begin
            state_n     = GAME_OVER;
            game_over_n = 1'b1;
            winner_n    = 1'b1;
          end else begin
            // tied at or past the target: drop both back to game point
            if (deuce) begin
              l_score_n = DEUCE_SCORE;
              r_score_n = DEUCE_SCORE;
            end
            state_n = ROUND;
          end
        end
        ROUND:     state_n = IDLE;
        GAME_OVER: state_n = GAME_OVER;
        default:   state_n = ROUND;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ROUND;
      l_point_d      <= 1'b0;
      r_point_d      <= 1'b0;
      l_score        <= '0;
      r_score        <= '0;
      game_over      <= 1'b0;
      winner         <= 1'b0;
      sk.reset_round <= 1'b1;
      sk.l_hex1      <= 7'b1111111;
      sk.l_hex0      <= 7'b1000000;
      sk.r_hex1      <= 7'b1111111;
      sk.r_hex0      <= 7'b1000000;
    end else begin
      state          <= state_n;
      l_point_d      <= sk.l_point;
      r_point_d      <= sk.r_point;
      l_score        <= l_score_n;
      r_score        <= r_score_n;
      game_over      <= game_over_n;
      winner         <= winner_n;
      sk.reset_round <= (state_n == ROUND);
      {sk.l_hex1, sk.l_hex0} <= hex_pair(l_score);
      {sk.r_hex1, sk.r_hex0} <= hex_pair(r_score);
    end
  end

  assign sk.l_score   = l_score;
  assign sk.r_score   = r_score;
  assign sk.game_over = game_over;
  assign sk.winner    = winner;
endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: defaults, win-by-two (target 3) and target 11 instances.
module tb_score_keeper;
  localparam logic [6:0] SEG0  = 7'b1000000;
  localparam logic [6:0] SEG1  = 7'b1111001;
  localparam logic [6:0] SEG7  = 7'b1111000;
  localparam logic [6:0] SEG9  = 7'b0010000;
  localparam logic [6:0] BLANK = 7'b1111111;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  score_keeper_if #(.SCORE_W(7)) i0 ();
  score_keeper_if #(.SCORE_W(7)) i1 ();
  score_keeper_if #(.SCORE_W(7)) i2 ();

  score_keeper #(.WIN_SCORE(7), .WIN_BY_TWO(0), .SCORE_W(7)) d0 (.clk(clk), .reset(reset), .sk(i0));
  score_keeper #(.WIN_SCORE(3), .WIN_BY_TWO(1), .SCORE_W(7)) d1 (.clk(clk), .reset(reset), .sk(i1));
  score_keeper #(.WIN_SCORE(11), .WIN_BY_TWO(0), .SCORE_W(7)) d2 (.clk(clk), .reset(reset), .sk(i2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    i0.l_point = 1'b1; i0.r_point = 1'b0; i0.new_game = 1'b0;
    i1.l_point = 1'b0; i1.r_point = 1'b0; i1.new_game = 1'b0;
    i2.l_point = 1'b0; i2.r_point = 1'b0; i2.new_game = 1'b0;
    step(3);
    reset = 1'b0;
    vectors++; if (i0.l_score !== 7'd0) begin miscompares++; $display("FAIL reset_l_score: got %0d want 0", i0.l_score); end
    vectors++; if (i0.r_score !== 7'd0) begin miscompares++; $display("FAIL reset_r_score: got %0d want 0", i0.r_score); end
    vectors++; if (i0.reset_round !== 1'b1) begin miscompares++; $display("FAIL reset_rr: got %b want 1", i0.reset_round); end
    vectors++; if (i0.game_over !== 1'b0) begin miscompares++; $display("FAIL reset_game_over: got %b want 0", i0.game_over); end
    vectors++; if (i0.winner !== 1'b0) begin miscompares++; $display("FAIL reset_winner: got %b want 0", i0.winner); end
    vectors++; if (i0.l_hex0 !== SEG0) begin miscompares++; $display("FAIL reset_l_hex0: got %b want %b", i0.l_hex0, SEG0); end
    vectors++; if (i0.l_hex1 !== BLANK) begin miscompares++; $display("FAIL reset_l_hex1: got %b want %b", i0.l_hex1, BLANK); end
    step(1);
    vectors++; if (i0.reset_round !== 1'b0) begin miscompares++; $display("FAIL reset_rr_one_cycle: got %b want 0", i0.reset_round); end
    step(3);
    vectors++; if (i0.l_score !== 7'd0) begin miscompares++; $display("FAIL reset_held_point: got %0d want 0", i0.l_score); end
    i0.l_point = 1'b0;
    step(2);
  endtask

  task automatic test_points_to_win;
    int rr_pulses;
    rr_pulses = 0;
    for (int k = 1; k <= 7; k++) begin
      i0.l_point = 1'b1;
      step(1);
      i0.l_point = 1'b0;
      vectors++; if (i0.l_score !== 7'(k)) begin miscompares++; $display("FAIL point_score[%0d]: got %0d want %0d", k, i0.l_score, k); end
      vectors++; if (i0.reset_round !== 1'b0) begin miscompares++; $display("FAIL point_rr_check[%0d]: got %b want 0", k, i0.reset_round); end
      step(1);
      if (i0.reset_round === 1'b1) rr_pulses++;
      if (k < 7) begin
        vectors++; if (i0.game_over !== 1'b0) begin miscompares++; $display("FAIL point_no_win[%0d]: got %b want 0", k, i0.game_over); end
      end else begin
        vectors++; if (i0.game_over !== 1'b1) begin miscompares++; $display("FAIL win_game_over: got %b want 1", i0.game_over); end
        vectors++; if (i0.winner !== 1'b0) begin miscompares++; $display("FAIL win_winner: got %b want 0", i0.winner); end
      end
      step(1);
      vectors++; if (i0.reset_round !== 1'b0) begin miscompares++; $display("FAIL point_rr_end[%0d]: got %b want 0", k, i0.reset_round); end
      step(2);
    end
    vectors++; if (rr_pulses !== 6) begin miscompares++; $display("FAIL round_pulses: got %0d want 6", rr_pulses); end
    i0.r_point = 1'b1;
    step(1);
    i0.r_point = 1'b0;
    step(3);
    vectors++; if (i0.r_score !== 7'd0) begin miscompares++; $display("FAIL over_r_ignored: got %0d want 0", i0.r_score); end
    vectors++; if (i0.l_score !== 7'd7) begin miscompares++; $display("FAIL over_l_hold: got %0d want 7", i0.l_score); end
    vectors++; if (i0.game_over !== 1'b1) begin miscompares++; $display("FAIL over_hold: got %b want 1", i0.game_over); end
    vectors++; if (i0.l_hex0 !== SEG7) begin miscompares++; $display("FAIL over_l_hex0: got %b want %b", i0.l_hex0, SEG7); end
  endtask

  task automatic test_new_game;
    i0.new_game = 1'b1;
    step(1);
    i0.new_game = 1'b0;
    vectors++; if (i0.l_score !== 7'd0) begin miscompares++; $display("FAIL new_game_l_score: got %0d want 0", i0.l_score); end
    vectors++; if (i0.game_over !== 1'b0) begin miscompares++; $display("FAIL new_game_over: got %b want 0", i0.game_over); end
    vectors++; if (i0.reset_round !== 1'b1) begin miscompares++; $display("FAIL new_game_rr: got %b want 1", i0.reset_round); end
    step(1);
    vectors++; if (i0.reset_round !== 1'b0) begin miscompares++; $display("FAIL new_game_rr_end: got %b want 0", i0.reset_round); end
    step(2);
  endtask

  task automatic test_simultaneous;
    i0.l_point = 1'b1;
    i0.r_point = 1'b1;
    step(1);
    i0.l_point = 1'b0;
    i0.r_point = 1'b0;
    vectors++; if (i0.reset_round !== 1'b1) begin miscompares++; $display("FAIL both_rr: got %b want 1", i0.reset_round); end
    step(1);
    vectors++; if (i0.reset_round !== 1'b0) begin miscompares++; $display("FAIL both_rr_end: got %b want 0", i0.reset_round); end
    vectors++; if (i0.l_score !== 7'd0) begin miscompares++; $display("FAIL both_l_score: got %0d want 0", i0.l_score); end
    vectors++; if (i0.r_score !== 7'd0) begin miscompares++; $display("FAIL both_r_score: got %0d want 0", i0.r_score); end
    step(2);
  endtask

  task automatic test_held_point;
    i0.l_point = 1'b1;
    step(20);
    i0.l_point = 1'b0;
    step(3);
    vectors++; if (i0.l_score !== 7'd1) begin miscompares++; $display("FAIL held_score: got %0d want 1", i0.l_score); end
    vectors++; if (i0.l_hex0 !== SEG1) begin miscompares++; $display("FAIL held_l_hex0: got %b want %b", i0.l_hex0, SEG1); end
    vectors++; if (i0.game_over !== 1'b0) begin miscompares++; $display("FAIL held_game_over: got %b want 0", i0.game_over); end
  endtask

  task automatic pulse_d1(input bit left);
    if (left) i1.l_point = 1'b1; else i1.r_point = 1'b1;
    step(1);
    i1.l_point = 1'b0;
    i1.r_point = 1'b0;
    step(4);
  endtask

  task automatic test_deuce;
    pulse_d1(1'b1); pulse_d1(1'b0); pulse_d1(1'b1); pulse_d1(1'b0);
    vectors++; if (i1.l_score !== 7'd2 || i1.r_score !== 7'd2) begin miscompares++; $display("FAIL deuce_2_2: got %0d-%0d want 2-2", i1.l_score, i1.r_score); end
    pulse_d1(1'b0);
    vectors++; if (i1.r_score !== 7'd3 || i1.game_over !== 1'b0) begin miscompares++; $display("FAIL deuce_r_lead: got r=%0d over=%b want r=3 over=0", i1.r_score, i1.game_over); end
    i1.l_point = 1'b1;
    step(1);
    i1.l_point = 1'b0;
    vectors++; if (i1.l_score !== 7'd3 || i1.r_score !== 7'd3) begin miscompares++; $display("FAIL deuce_3_3: got %0d-%0d want 3-3", i1.l_score, i1.r_score); end
    step(1);
    vectors++; if (i1.l_score !== 7'd2 || i1.r_score !== 7'd2) begin miscompares++; $display("FAIL deuce_collapse: got %0d-%0d want 2-2", i1.l_score, i1.r_score); end
    vectors++; if (i1.reset_round !== 1'b1) begin miscompares++; $display("FAIL deuce_rr: got %b want 1", i1.reset_round); end
    step(3);
    pulse_d1(1'b1);
    vectors++; if (i1.l_score !== 7'd3 || i1.game_over !== 1'b0) begin miscompares++; $display("FAIL deuce_adv: got l=%0d over=%b want l=3 over=0", i1.l_score, i1.game_over); end
    i1.l_point = 1'b1;
    step(1);
    i1.l_point = 1'b0;
    vectors++; if (i1.l_score !== 7'd4) begin miscompares++; $display("FAIL deuce_final_score: got %0d want 4", i1.l_score); end
    step(1);
    vectors++; if (i1.game_over !== 1'b1) begin miscompares++; $display("FAIL deuce_game_over: got %b want 1", i1.game_over); end
    vectors++; if (i1.winner !== 1'b0) begin miscompares++; $display("FAIL deuce_winner: got %b want 0", i1.winner); end
    vectors++; if (i1.reset_round !== 1'b0) begin miscompares++; $display("FAIL deuce_over_rr: got %b want 0", i1.reset_round); end
  endtask

  task automatic test_tens_digit;
    for (int k = 0; k < 9; k++) begin
      i2.l_point = 1'b1;
      step(1);
      i2.l_point = 1'b0;
      step(4);
    end
    vectors++; if (i2.l_score !== 7'd9) begin miscompares++; $display("FAIL tens_score9: got %0d want 9", i2.l_score); end
    vectors++; if (i2.l_hex1 !== BLANK || i2.l_hex0 !== SEG9) begin miscompares++; $display("FAIL tens_hex9: got %b %b want %b %b", i2.l_hex1, i2.l_hex0, BLANK, SEG9); end
    i2.l_point = 1'b1;
    step(1);
    i2.l_point = 1'b0;
    vectors++; if (i2.l_score !== 7'd10) begin miscompares++; $display("FAIL tens_score10: got %0d want 10", i2.l_score); end
    vectors++; if (i2.l_hex1 !== BLANK || i2.l_hex0 !== SEG9) begin miscompares++; $display("FAIL tens_hex_lag: got %b %b want %b %b", i2.l_hex1, i2.l_hex0, BLANK, SEG9); end
    step(1);
    vectors++; if (i2.l_hex1 !== SEG1 || i2.l_hex0 !== SEG0) begin miscompares++; $display("FAIL tens_hex10: got %b %b want %b %b", i2.l_hex1, i2.l_hex0, SEG1, SEG0); end
    vectors++; if (i2.game_over !== 1'b0) begin miscompares++; $display("FAIL tens_no_win: got %b want 0", i2.game_over); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_points_to_win();
    test_new_game();
    test_simultaneous();
    test_held_point();
    test_deuce();
    test_tens_digit();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
